// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared widths, RW encoding and arbiter state type for the 6502 memory bus
package mem_bus_pkg;
    localparam int ADR_W = 16;
    localparam int DATA_W = 8;
    localparam logic RW_READ = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_t;
endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority encoder starting at a pointer, with an exclude mask
module rr_picker #(
    parameter int N = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    input  logic [N-1:0]     excl,
    output logic             valid,
    output logic [IDX_W-1:0] win
);
    logic [N-1:0] cand;
    logic [IDX_W-1:0] j;
    assign cand = req & ~excl;
    // Scan from start downward in reverse so the candidate closest to start is written last
    always_comb begin
        valid = 1'b0;
        win = '0;
        j = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IDX_W'((int'(start) + k) % N);
            if (cand[j]) begin
                valid = 1'b1;
                win = j;
            end
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin owner of the shared 6502 memory bus with bounded hold and lock
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int MAX_HOLD = 8
) (
    input  logic                          clk,
    input  logic                          n_reset,
    input  logic [NUM_MASTERS-1:0]        req,
    input  logic [NUM_MASTERS-1:0]        lock,
    input  logic [ADR_W*NUM_MASTERS-1:0]  m_adr,
    input  logic [NUM_MASTERS-1:0]        m_rw,
    input  logic [DATA_W*NUM_MASTERS-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]        gnt,
    output logic [NUM_MASTERS-1:0]        rdy,
    output logic [NUM_MASTERS-1:0]        rvalid,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [ADR_W-1:0]              mem_adr,
    output logic                          mem_rw,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata
);
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    arb_state_t state;
    logic [IDX_W-1:0] owner, rr_ptr, win, win_next;
    logic [7:0] hold_cnt, hold_inc;
    logic [NUM_MASTERS-1:0] own_mask, win_mask, excl;
    logic win_valid, take, release_bus;

    assign own_mask = NUM_MASTERS'(1) << owner;
    assign win_mask = NUM_MASTERS'(1) << win;
    assign excl = (state == ARB_OWNED) ? own_mask : '0;
    assign win_next = (win == LAST_IDX) ? '0 : win + 1'b1;
    assign hold_inc = (hold_cnt >= HOLD_MAX) ? HOLD_MAX : hold_cnt + 8'd1;
    assign take = win_valid && (state == ARB_IDLE || !req[owner] || (!lock[owner] && hold_cnt >= HOLD_LAST));
    assign release_bus = state == ARB_OWNED && !req[owner] && !win_valid;
    assign rdy = gnt;
    assign m_rdata = mem_rdata;

    rr_picker #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_pick (
        .req(req),
        .start(rr_ptr),
        .excl(excl),
        .valid(win_valid),
        .win(win)
    );

    // Ownership on the CPU's falling edge: hand over to the RR winner, go idle, or keep counting hold time
    always_ff @(negedge clk) begin
        if (!n_reset) begin
            state <= ARB_IDLE;
            owner <= '0;
            rr_ptr <= '0;
            hold_cnt <= '0;
            gnt <= '0;
            rvalid <= '0;
        end else begin
            rvalid <= gnt & m_rw;
            if (take) begin
                state <= ARB_OWNED;
                owner <= win;
                rr_ptr <= win_next;
                hold_cnt <= '0;
                gnt <= win_mask;
            end else if (release_bus) begin
                state <= ARB_IDLE;
                hold_cnt <= '0;
                gnt <= '0;
            end else if (state == ARB_OWNED) begin
                hold_cnt <= hold_inc;
            end
        end
    end

    // Bus mux follows gnt directly so a write in the reset cycle still reaches memory
    always_comb begin
        mem_adr = '0;
        mem_rw = RW_READ;
        mem_wdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gnt[i]) begin
                mem_adr = m_adr[ADR_W*i +: ADR_W];
                mem_rw = m_rw[i];
                mem_wdata = m_wdata[DATA_W*i +: DATA_W];
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench with a behavioural arbiter/memory model
module tb_mem_bus_arbiter;
    localparam int N = 3;
    localparam int MAXH = 8;

    logic clk = 1'b1;
    logic n_reset;
    logic [N-1:0] req, lock, m_rw, gnt, rdy, rvalid;
    logic [16*N-1:0] m_adr;
    logic [8*N-1:0] m_wdata;
    logic [7:0] m_rdata, mem_wdata, mem_rdata;
    logic [15:0] mem_adr;
    logic mem_rw;

    logic [15:0] a_v [N];
    logic [7:0] d_v [N];
    logic [7:0] ram [65536];
    logic [7:0] sh [65536];

    typedef struct {
        logic [N-1:0] gnt;
        logic [N-1:0] rv;
        logic [7:0] rd;
        logic [15:0] adr;
        logic rw;
        logic [7:0] wd;
    } exp_t;
    exp_t q[$];

    int m_owner = -1;
    int m_hold = 0;
    int m_ptr = 0;
    logic [N-1:0] pinned = '0;
    logic [N-1:0] prev_req = '0;
    int checks = 0;
    int failures = 0;

    mem_bus_arbiter #(.NUM_MASTERS(N), .MAX_HOLD(MAXH)) dut (
        .clk(clk),
        .n_reset(n_reset),
        .req(req),
        .lock(lock),
        .m_adr(m_adr),
        .m_rw(m_rw),
        .m_wdata(m_wdata),
        .gnt(gnt),
        .rdy(rdy),
        .rvalid(rvalid),
        .m_rdata(m_rdata),
        .mem_adr(mem_adr),
        .mem_rw(mem_rw),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            m_adr[16*i +: 16] = a_v[i];
            m_wdata[8*i +: 8] = d_v[i];
        end
    end

    // Synchronous RAM with one-cycle read latency, clocked with the DUT
    always @(negedge clk) begin
        if (mem_rw === 1'b0) ram[mem_adr] <= mem_wdata;
        mem_rdata <= ram[mem_adr];
    end

    function automatic int pick(int start, int ex, logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int j = (start + k) % N;
            if (r[j] && j != ex) return j;
        end
        return -1;
    endfunction

    function automatic void grant(int w);
        m_owner = w;
        m_hold = 0;
        m_ptr = (w + 1) % N;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic commit(input bit rst_n, input logic [N-1:0] r, input logic [N-1:0] l);
        exp_t e;
        int w;
        n_reset = rst_n;
        req = r;
        lock = l;
        for (int i = 0; i < N; i++) begin
            if (!pinned[i] && !(prev_req[i] && m_owner != i)) begin
                a_v[i] = 16'h0200 | 16'($urandom_range(0, 15));
                d_v[i] = 8'($urandom);
                m_rw[i] = 1'($urandom);
            end
        end
        prev_req = r;
        e.rv = '0;
        e.rd = '0;
        if (m_owner >= 0) begin
            if (m_rw[m_owner]) begin
                e.rv = N'(1) << m_owner;
                e.rd = sh[a_v[m_owner]];
            end else begin
                sh[a_v[m_owner]] = d_v[m_owner];
            end
        end
        if (!rst_n) begin
            m_owner = -1;
            m_hold = 0;
            m_ptr = 0;
            e.rv = '0;
        end else if (m_owner < 0) begin
            w = pick(m_ptr, -1, r);
            if (w >= 0) grant(w);
        end else begin
            w = pick(m_ptr, m_owner, r);
            if (!r[m_owner]) begin
                if (w >= 0) grant(w);
                else m_owner = -1;
            end else if (w >= 0 && !l[m_owner] && m_hold >= MAXH - 1) begin
                grant(w);
            end else begin
                m_hold = (m_hold < MAXH) ? m_hold + 1 : MAXH;
            end
        end
        e.gnt = (m_owner >= 0) ? N'(1) << m_owner : '0;
        e.adr = (m_owner >= 0) ? a_v[m_owner] : 16'h0000;
        e.rw = (m_owner >= 0) ? m_rw[m_owner] : 1'b1;
        e.wd = (m_owner >= 0) ? d_v[m_owner] : 8'h00;
        q.push_back(e);
    endtask

    task automatic cyc(input bit rst_n, input logic [N-1:0] r, input logic [N-1:0] l);
        tick();
        commit(rst_n, r, l);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest expectation each cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("gnt", 32'(gnt), 32'(e.gnt));
                chk("rdy", 32'(rdy), 32'(e.gnt));
                chk("rvalid", 32'(rvalid), 32'(e.rv));
                chk("mem_adr", 32'(mem_adr), 32'(e.adr));
                chk("mem_rw", 32'(mem_rw), 32'(e.rw));
                chk("mem_wdata", 32'(mem_wdata), 32'(e.wd));
                if (e.rv != '0) chk("m_rdata", 32'(m_rdata), 32'(e.rd));
            end
        end
    end

    initial begin
        logic [N-1:0] r, l;
        bit rs;
        for (int a = 0; a < 65536; a++) begin
            ram[a] = 8'(a ^ (a >> 8));
            sh[a] = 8'(a ^ (a >> 8));
        end
        for (int i = 0; i < N; i++) begin
            a_v[i] = '0;
            d_v[i] = '0;
        end
        m_rw = '1;
        commit(0, '0, '0);
        cyc(0, '0, '0);
        // CPU read of 0x8000
        tick();
        a_v[0] = 16'h8000;
        m_rw[0] = 1'b1;
        pinned = 3'b001;
        commit(1, 3'b001, '0);
        repeat (3) cyc(1, 3'b001, '0);
        pinned = '0;
        // All three masters contend from reset
        cyc(0, '0, '0);
        repeat (30) cyc(1, 3'b111, '0);
        // Master 1 locked while the CPU waits, then unlocks
        cyc(0, '0, '0);
        repeat (2) cyc(1, 3'b010, '0);
        repeat (20) cyc(1, 3'b011, 3'b010);
        repeat (3) cyc(1, 3'b011, '0);
        // Master 2 writes 0x5A to 0x0200, drops req, CPU reads it back
        cyc(0, '0, '0);
        tick();
        a_v[2] = 16'h0200;
        d_v[2] = 8'h5A;
        m_rw[2] = 1'b0;
        pinned = 3'b100;
        commit(1, 3'b100, '0);
        cyc(1, 3'b100, '0);
        tick();
        a_v[0] = 16'h0200;
        m_rw[0] = 1'b1;
        pinned = 3'b101;
        commit(1, 3'b101, '0);
        repeat (3) cyc(1, 3'b001, '0);
        // Reset pulse while the CPU is reading
        tick();
        a_v[0] = 16'h8000;
        pinned = 3'b001;
        commit(1, 3'b001, '0);
        cyc(1, 3'b001, '0);
        cyc(0, 3'b001, '0);
        repeat (3) cyc(1, 3'b001, '0);
        pinned = '0;
        // Long single-master ownership, then contention
        cyc(0, '0, '0);
        repeat (300) cyc(1, 3'b010, '0);
        repeat (4) cyc(1, 3'b011, '0);
        // Random sticky requests and locks with rare resets
        r = '0;
        l = '0;
        repeat (600) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
                if ($urandom_range(0, 3) == 0) l[i] = ~l[i];
            end
            rs = ($urandom_range(0, 199) != 0);
            cyc(rs, r, l);
        end
        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single 6502 memory bus (16-bit address, 8-bit data, RW) between up to NUM_MASTERS requesters: the CPU core on master 0, plus DMA/loader engines. A granted master drives the memory bus. Ungranted masters see rdy low and must stall. Grants rotate round-robin with a bounded hold time and a lock for atomic read-modify-write sequences. The block sits between the masters and the RAM/ROM decode.

## Interface
Parameters:
- NUM_MASTERS, 3: number of requesters, 2..8; master 0 is the CPU.
- MAX_HOLD, 8: maximum consecutive granted cycles while another master is waiting, 1..255.

Ports (all sequential logic on the falling edge of clk, matching the CPU):
- clk  in  1  system clock
- n_reset  in  1  reset, synchronous, active-low
- req  in  NUM_MASTERS  bus request, one bit per master
- lock  in  NUM_MASTERS  owner requests no preemption
- m_adr  in  16*NUM_MASTERS  master i address at [16i+15:16i]
- m_rw  in  NUM_MASTERS  1 = read, 0 = write
- m_wdata  in  8*NUM_MASTERS  master i write data at [8i+7:8i]
- gnt  out  NUM_MASTERS  one-hot (or zero) grant, registered
- rdy  out  NUM_MASTERS  equals gnt; master stalls while low
- rvalid  out  NUM_MASTERS  read data valid for master i
- m_rdata  out  8  mem_rdata passthrough, broadcast to all masters
- mem_adr  out  16  memory address
- mem_rw  out  1  memory RW
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data

## Operation
- States: IDLE (no owner) and OWNED (owner index valid). Registers: state, owner, rr_ptr, hold_cnt, rvalid.
- **Arbitration:** round-robin search of req starting at rr_ptr. After a grant, rr_ptr is set to owner+1, modulo NUM_MASTERS.
- **IDLE:**
  - If any req bit is set, grant the winner at the next edge and go to OWNED with hold_cnt=0.
  - Otherwise stay in IDLE.
- **OWNED, req[owner] low:**
  - Re-arbitrate among the others at the same edge, with no dead cycle.
  - If no other request is set, go to IDLE.
- **OWNED, req[owner] high:**
  - If no other master requests, keep the grant indefinitely. hold_cnt saturates at MAX_HOLD.
  - If another master requests, hold_cnt increments each cycle.
  - When hold_cnt reaches MAX_HOLD-1 and lock[owner]=0, rotate to the RR winner, excluding the owner. hold_cnt resets to 0.
  - lock[owner]=1 blocks preemption regardless of hold_cnt.
  - lock from non-owners is ignored.
- **Bus mux:** combinational from gnt.
  - When owned: mem_adr/mem_rw/mem_wdata = the owner's m_adr/m_rw/m_wdata.
  - In IDLE: mem_adr=16'h0000, mem_rw=1 (read), mem_wdata=8'h00.
- **Read return:** rvalid[i] <= gnt[i] & m_rw[i]. It is delivered even if the grant moved away at that edge.

## Timing
- Reset values: gnt=0, rdy=0, rvalid=0, state IDLE, owner=0, hold_cnt=0, rr_ptr=0 (CPU wins the first contended arbitration), mem_adr=0x0000, mem_rw=1, mem_wdata=0x00.
- Request to grant latency: 1 edge. req is sampled at edge N; gnt is high after edge N.
- Handshake: a transfer occurs in each cycle where gnt[i]=1. Masters hold m_adr/m_rw/m_wdata stable while req is high and gnt is low.
- Write: committed by memory in the cycle gnt and mem_rw=0 are presented.
- Read: memory is synchronous with 1-cycle latency. m_rdata is valid in the cycle rvalid[i]=1, one edge after the address cycle.
- Back-to-back grants to different masters are allowed on consecutive cycles.
- Reset mid-transfer: at the reset edge, gnt and rvalid clear and any pending read is dropped. A write presented in the reset cycle still reaches memory, because the mux is combinational. No rvalid appears after reset.
- Single master: never preempted, 100% throughput.

## Structure
- Package mem_bus_pkg holds:
  - ADR_W=16 and DATA_W=8
  - RW_READ=1'b1 and RW_WRITE=1'b0
  - arb_state_t enum {ARB_IDLE, ARB_OWNED}
- The CPU and future bus agents import this package.
- Sub-module rr_picker: purely combinational round-robin priority encoder.
  - Inputs: request vector, start pointer, exclude mask.
  - Outputs: valid flag and winner index.
  - The arbiter instantiates it once.

## Test plan
- Reset, then req=3'b001 with m_adr0=0x8000 read -> gnt=001 after 1 edge, mem_adr=0x8000, rvalid[0]=1 on the following edge with m_rdata equal to the memory contents.
- req=3'b111 from reset, all held high, MAX_HOLD=8 -> grants master 0 for 8 cycles, then master 1 for 8, then master 2 for 8, then back to 0.
- Master 1 owned with lock[1]=1 and req[0] waiting 20 cycles -> no preemption. lock drops -> gnt moves to master 0 after hold_cnt is satisfied (at most 1 edge).
- Master 2 writes 0x5A to 0x0200 then drops req while req[0] is high -> gnt switches to 001 on the next edge with no IDLE cycle, and memory 0x0200 reads back 0x5A.
- Master 0 is granted and reading; n_reset is pulsed low for 1 cycle -> gnt=0, rvalid=0 after that edge, mem_rw=1, and the arbiter re-grants master 0 one edge after reset is released.
- NUM_MASTERS=2, only master 1 requests for 300 cycles -> never preempted, hold_cnt saturates at MAX_HOLD with no wrap.
